// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - memory port bundle between the copy engine and byte-addressed memory
interface mem_copy_engine_if;
  logic        mem_en;
  logic        mem_wr;
  logic        mem_wide;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_wide, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_wide, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy DMA helper, word transfers with a byte tail
// Optional pattern-fill mode enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src,
  input  logic [15:0]      dst,
  input  logic [LEN_W-1:0] len,
`ifdef MEM_COPY_FILL_EN
  input  logic             fill,
  input  logic [15:0]      pattern,
`endif
  output logic             busy,
  output logic             done,
  mem_copy_engine_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t           state, state_nxt;
  logic [15:0]      src_q, dst_q;
  logic [LEN_W-1:0] count_q, count_nxt, step;
  logic [15:0]      addr_step;
  logic             wide;
  logic             done_q;
  logic             fill_mode, start_fill;
  logic [15:0]      wide_word;
  logic [7:0]       narrow_byte;

`ifdef MEM_COPY_FILL_EN
  logic             fill_q;
  logic [15:0]      pattern_q;

  assign fill_mode   = fill_q;
  assign start_fill  = fill;
  assign wide_word   = fill_q ? pattern_q : mem.mem_rdata;
  assign narrow_byte = fill_q ? pattern_q[7:0] : mem.mem_rdata[15:8];
`else
  assign fill_mode   = 1'b0;
  assign start_fill  = 1'b0;
  assign wide_word   = mem.mem_rdata;
  assign narrow_byte = mem.mem_rdata[15:8];
`endif

  // Word transfers while at least two bytes remain; a single tail byte goes narrow.
  assign wide      = (count_q > LEN_W'(1));
  assign step      = wide ? LEN_W'(2) : LEN_W'(1);
  assign addr_step = wide ? 16'd2 : 16'd1;
  assign count_nxt = count_q - step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef MEM_COPY_FILL_EN
      fill_q    <= 1'b0;
      pattern_q <= '0;
`endif
    end else begin
      state  <= state_nxt;
      // done trails FIN by a cycle so it lands in the first idle cycle with busy low.
      done_q <= (state == FIN);
      if (state == IDLE && start) begin
        src_q   <= src;
        dst_q   <= dst;
        count_q <= len;
`ifdef MEM_COPY_FILL_EN
        fill_q    <= fill;
        pattern_q <= pattern;
`endif
      end
      if (state == WR) begin
        src_q   <= src_q + addr_step;
        dst_q   <= dst_q + addr_step;
        count_q <= count_nxt;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_wide  = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)      state_nxt = FIN;
          else if (start_fill) state_nxt = WR;
          else                state_nxt = RD;
        end
      end
      RD: begin
        mem.mem_en   = 1'b1;
        mem.mem_wide = wide;
        mem.mem_addr = src_q;
        state_nxt    = WR;
      end
      WR: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_wide  = wide;
        mem.mem_addr  = dst_q;
        mem.mem_wdata = wide ? wide_word : {8'h00, narrow_byte};
        if (count_nxt == '0) state_nxt = FIN;
        else if (fill_mode)  state_nxt = WR;
        else                 state_nxt = RD;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset kills the port in the same cycle so an in-flight write never lands.
    if (reset) begin
      mem.mem_en    = 1'b0;
      mem.mem_wr    = 1'b0;
      mem.mem_wide  = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
    end
  end

  assign busy = (state != IDLE) && !reset;
  assign done = done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - randomized self-checking bench for mem_copy_engine
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done;
`ifdef MEM_COPY_FILL_EN
  logic        fill = 1'b0;
  logic [15:0] pattern = '0;
`endif

  mem_copy_engine_if mif ();

  mem_copy_engine #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_COPY_FILL_EN
    .fill(fill), .pattern(pattern),
`endif
    .busy(busy), .done(done), .mem(mif)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  logic [7:0] img [65536];
  logic [7:0] exp_mem [65536];
  logic       load = 1'b0;

  // Memory model: big-endian wide, narrow read in [15:8], narrow write from [7:0].
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 65536; i++) mem[i] = img[i];
    end else if (mif.mem_en && !mif.mem_wr) begin
      if (mif.mem_wide) mif.mem_rdata <= {mem[mif.mem_addr], mem[16'(mif.mem_addr + 16'd1)]};
      else              mif.mem_rdata <= {mem[mif.mem_addr], 8'h00};
    end else if (mif.mem_en && mif.mem_wr) begin
      if (mif.mem_wide) begin
        mem[mif.mem_addr] = mif.mem_wdata[15:8];
        mem[16'(mif.mem_addr + 16'd1)] = mif.mem_wdata[7:0];
      end else begin
        mem[mif.mem_addr] = mif.mem_wdata[7:0];
      end
    end
  end

  int en_n = 0, wide_wr_n = 0, narrow_wr_n = 0, viol_n = 0, done_n = 0;
  always @(negedge clk) begin
    if (mif.mem_en) en_n++;
    if (mif.mem_wr && !mif.mem_en) viol_n++;
    if (mif.mem_en && mif.mem_wr) begin
      if (mif.mem_wide) wide_wr_n++;
      else              narrow_wr_n++;
    end
    if (done) done_n++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic load_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) d++;
    return d;
  endfunction

  task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input int l, input bit f, input logic [15:0] pat, input bit poke);
    int cyc, exp_lat, e0, w0, n0, v0, dn0, nxfer;
    for (int i = 0; i < 65536; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < l; i++) begin
      if (f) exp_mem[16'(d + i)] = (i < (l & ~1) && (i % 2 == 0)) ? pat[15:8] : pat[7:0];
      else   exp_mem[16'(d + i)] = exp_mem[16'(s + i)];
    end
    nxfer   = (l + 1) / 2;
    exp_lat = f ? 2 + nxfer : 2 + 2 * nxfer;
    e0 = en_n; w0 = wide_wr_n; n0 = narrow_wr_n; v0 = viol_n; dn0 = done_n;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = 16'(l);
`ifdef MEM_COPY_FILL_EN
    fill = f; pattern = pat;
`endif
    @(negedge clk);
    cyc = 1;
    check({tag, "_busy1"}, busy, 1'b1);
    while (!done && cyc < exp_lat + 20) begin
      start = (poke && cyc == 2);
      src = ~s; len = 16'd7;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk); #1;
    check({tag, "_done_pulses"}, done_n - dn0, 1);
    check({tag, "_en_cycles"}, en_n - e0, f ? nxfer : 2 * nxfer);
    check({tag, "_wide_wr"}, wide_wr_n - w0, l / 2);
    check({tag, "_narrow_wr"}, narrow_wr_n - n0, l % 2);
    check({tag, "_wr_wo_en"}, viol_n - v0, 0);
    check({tag, "_mem"}, mem_diff(), 0);
  endtask

  initial begin
    int l, dn0, wrs, cyc;
    logic [15:0] s, d;
    for (int i = 0; i < 65536; i++) img[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ctl", {mif.mem_en, mif.mem_wr, mif.mem_wide}, 3'b000);
    check("rst_addr", mif.mem_addr, 16'h0000);
    check("rst_wdata", mif.mem_wdata, 16'h0000);
    load_img();

    // Even aligned copy
    img[16'h0100] = 8'h11; img[16'h0101] = 8'h22; img[16'h0102] = 8'h33; img[16'h0103] = 8'h44;
    load_img();
    run_copy("even", 16'h0100, 16'h0200, 4, 1'b0, 16'h0, 1'b1);
    check("even_b3", mem[16'h0203], 8'h44);

    // Odd unaligned copy, byte after the block untouched
    run_copy("odd", 16'h0101, 16'h0300, 3, 1'b0, 16'h0, 1'b0);
    check("odd_b2", mem[16'h0302], img[16'h0103]);
    check("odd_untouched", mem[16'h0303], img[16'h0303]);

    run_copy("len0", 16'h1234, 16'h5678, 0, 1'b0, 16'h0, 1'b0);

    // Source wraps through 0xFFFF
    img[16'hFFFF] = 8'hAB; img[16'h0000] = 8'hCD;
    load_img();
    run_copy("wrap", 16'hFFFF, 16'h0400, 2, 1'b0, 16'h0, 1'b0);
    check("wrap_b0", mem[16'h0400], 8'hAB);
    check("wrap_b1", mem[16'h0401], 8'hCD);

    // Reset during the second write
    load_img();
    for (int i = 0; i < 65536; i++) exp_mem[i] = img[i];
    exp_mem[16'h0700] = img[16'h0600];
    exp_mem[16'h0701] = img[16'h0601];
    @(negedge clk);
    start = 1'b1; src = 16'h0600; dst = 16'h0700; len = 16'd8;
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    wrs = 0; cyc = 0;
    while (wrs < 2 && cyc < 50) begin
      if (mif.mem_en && mif.mem_wr) wrs++;
      if (wrs < 2) begin @(negedge clk); cyc++; end
    end
    check("rstmid_reached", wrs, 2);
    reset = 1'b1;
    #1;
    check("rstmid_en_now", mif.mem_en, 1'b0);
    dn0 = done_n;
    @(negedge clk);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_en", mif.mem_en, 1'b0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("rstmid_no_done", done_n - dn0, 0);
    check("rstmid_busy_after", busy, 1'b0);
    check("rstmid_mem", mem_diff(), 0);

    // Random copies; a few with dst<=src overlap
    for (int t = 0; t < 20; t++) begin
      l = $urandom_range(0, 33);
      s = 16'($urandom);
      if (t % 5 == 4) d = s - 16'($urandom_range(0, 3));
      else            d = s + 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
      run_copy($sformatf("rnd%0d", t), s, d, l, 1'b0, 16'h0, (l > 0) && ($urandom_range(0, 1) == 1));
    end

`ifdef MEM_COPY_FILL_EN
    run_copy("fill", 16'h0000, 16'h0500, 5, 1'b1, 16'hA55A, 1'b0);
    check("fill_b0", mem[16'h0500], 8'hA5);
    check("fill_b4", mem[16'h0504], 8'h5A);
    for (int t = 0; t < 5; t++)
      run_copy($sformatf("rfill%0d", t), 16'h0, 16'($urandom), $urandom_range(0, 17), 1'b1,
               16'($urandom), 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
